mips_pc_sequencer: RTL and testbench
====================================

MIPS_PC_SEQUENCER -- requirements
Module: mips_pc_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock shared with mips_core.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled only on rising clock.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin execution.
REQ-004 SHALL have port halt, input, 1 bit: external stop request.
REQ-005 SHALL have port stall, input, 1 bit: holds PC in RUN when high.
REQ-006 SHALL have port last_addr, input, 8 bits: word address of final instruction.
REQ-007 SHALL have port instruction, input, 32 bits: current instruction from instruction memory.
REQ-008 SHALL have ports branch, jump, zero, inputs, 1 bit each: Control_Unit Branch/Jump and ALU zero.
REQ-009 SHALL have port program_counter, output, 8 bits: word address fed to mips_core.
REQ-010 SHALL have port core_enable, output, 1 bit: high when the current instruction may commit (RUN and not stall).
REQ-011 SHALL have port done, output, 1 bit: high while in HALTED.

Function
REQ-012 SHALL implement states IDLE, RUN and HALTED.
REQ-013 IDLE: program_counter holds 0; start=1 and halt=0 -> RUN next cycle; otherwise stay.
REQ-014 RUN, stall=0: program_counter updates every clock to next_pc (REQ-016..019).
REQ-015 RUN, stall=1: program_counter and state hold; core_enable=0.
REQ-016 Default next_pc SHALL be program_counter+1, modulo 256 (255 -> 0).
REQ-017 Branch taken (branch=1 and zero=1): next_pc = program_counter + 1 + instruction[7:0], 8-bit modulo arithmetic; offset is the low byte of the sign-extended immediate.
REQ-018 Jump (jump=1): next_pc = instruction[7:0]; jump SHALL take priority over branch.
REQ-019 branch=1 and zero=0: next_pc = program_counter+1.
REQ-020 RUN: halt=1 (regardless of stall) -> HALTED next cycle; program_counter holds; current instruction is not committed (core_enable=0 that cycle).
REQ-021 RUN, stall=0, program_counter==last_addr, halt=0: instruction commits, then HALTED; program_counter holds last_addr.
REQ-022 HALTED: program_counter holds; start=1 and halt=0 -> program_counter=0 and RUN next cycle.
REQ-023 halt SHALL take priority over start in every state.
REQ-024 Latency: new program_counter visible one clock after the edge that samples branch/jump/zero; no combinational path from inputs to program_counter.

Reset
REQ-025 reset_n=0 at a rising edge SHALL force state=IDLE, program_counter=0, core_enable=0, done=0, and (if compiled) retired_count=0.
REQ-026 Reset SHALL win over start, halt and stall, including mid-RUN.

Configuration
REQ-027 Macro MIPS_PC_RETIRE_COUNT_EN defined: adds output retired_count, 16 bits, incremented on every clock with core_enable=1, wrapping 65535 -> 0, held in IDLE/HALTED, cleared on restart from HALTED.
REQ-028 MIPS_PC_RETIRE_COUNT_EN undefined: no retired_count port, no counter logic; all other behaviour identical.

Structure
REQ-029 Package mips_pc_pkg SHALL hold the state enumeration, PC_WIDTH=8, RESET_VECTOR=0.
REQ-030 Next-PC computation SHALL be sub-module mips_next_pc (combinational: pc, instruction, branch, jump, zero -> next_pc); state machine and registers stay in mips_pc_sequencer.

Verification
REQ-031 Reset, start, last_addr=3, no branch/jump -> program_counter 0,1,2,3 on successive cycles, then done=1, program_counter=3 held.
REQ-032 RUN at pc=5, branch=1, zero=1, instruction[7:0]=8'hFC (-4) -> next program_counter=2; same with zero=0 -> 6.
REQ-033 RUN at pc=5, jump=1, branch=1, zero=1, instruction[7:0]=8'h20 -> next program_counter=32 (jump priority).
REQ-034 pc=255, last_addr=0, no control -> next program_counter=0, then HALTED on following cycle.
REQ-035 stall=1 for 3 cycles at pc=4 -> program_counter stays 4, core_enable=0; retired_count (if compiled) unchanged; resumes at 5.
REQ-036 reset_n=0 at pc=7 mid-RUN with start=1, halt=1 -> IDLE, program_counter=0, done=0 next cycle.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS program-counter sequencer.
package mips_pc_pkg;

  localparam int PC_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] RESET_VECTOR = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module mips_next_pc
  import mips_pc_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         instruction,
  input  logic                branch,
  input  logic                jump,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] pc_inc;
  logic                unused_instr_hi;

  // Only the low byte of the immediate/target matters in an 8-bit word space.
  assign unused_instr_hi = ^instruction[31:PC_WIDTH];
  assign pc_inc          = pc + PC_WIDTH'(1);

  always_comb begin
    next_pc = pc_inc;
    if (jump) begin
      next_pc = instruction[PC_WIDTH-1:0];
    end else if (branch && zero) begin
      next_pc = pc_inc + instruction[PC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mips_pc_sequencer.sv
// PC sequencer FSM (IDLE/RUN/HALTED) driving mips_core.
// Optional retired-instruction counter: define MIPS_PC_RETIRE_COUNT_EN.
//
// state     | meaning
// ST_IDLE   | after reset, PC parked at 0, waiting for start
// ST_RUN    | fetching/committing; PC advances unless stalled
// ST_HALTED | program ended or halted; PC frozen, done high
module mips_pc_sequencer
  import mips_pc_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                halt,
  input  logic                stall,
  input  logic [PC_WIDTH-1:0] last_addr,
  input  logic [31:0]         instruction,
  input  logic                branch,
  input  logic                jump,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic                core_enable,
  output logic                done
`ifdef MIPS_PC_RETIRE_COUNT_EN
  ,
  output logic [15:0]         retired_count
`endif
);

  seq_state_t          state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] next_pc;
  logic                restart;

  mips_next_pc u_next_pc (
    .pc          (program_counter),
    .instruction (instruction),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      program_counter <= RESET_VECTOR;
    end else begin
      state           <= state_nxt;
      program_counter <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = program_counter;
    core_enable = 1'b0;
    restart     = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_nxt = RESET_VECTOR;
        if (start && !halt) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt = ST_HALTED;
        end else if (!stall) begin
          core_enable = 1'b1;
          // The final instruction commits in place; PC stays on it.
          if (program_counter == last_addr) state_nxt = ST_HALTED;
          else                              pc_nxt    = next_pc;
        end
      end
      ST_HALTED: begin
        if (start && !halt) begin
          state_nxt = ST_RUN;
          pc_nxt    = RESET_VECTOR;
          restart   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pc_nxt    = RESET_VECTOR;
      end
    endcase
  end

  assign done = (state == ST_HALTED);

`ifdef MIPS_PC_RETIRE_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n)         retired_count <= '0;
    else if (restart)     retired_count <= '0;
    else if (core_enable) retired_count <= retired_count + 16'd1;
  end
`else
  logic unused_restart;
  assign unused_restart = restart;
`endif

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Self-checking bench: directed scenarios plus randomized run against a behavioural model.
module tb_mips_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n, start, halt, stall, branch, jump, zero;
  logic [7:0]  last_addr;
  logic [31:0] instruction;
  logic [7:0]  program_counter;
  logic        core_enable, done;
`ifdef MIPS_PC_RETIRE_COUNT_EN
  logic [15:0] retired_count;
`endif

  int total = 0;
  int bad   = 0;

  // model: mode 0=idle 1=run 2=halted
  int m_mode = 0;
  int m_pc   = 0;
  int m_ret  = 0;

  mips_pc_sequencer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .halt            (halt),
    .stall           (stall),
    .last_addr       (last_addr),
    .instruction     (instruction),
    .branch          (branch),
    .jump            (jump),
    .zero            (zero),
    .program_counter (program_counter),
    .core_enable     (core_enable),
    .done            (done)
`ifdef MIPS_PC_RETIRE_COUNT_EN
    ,
    .retired_count   (retired_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic rst, input logic st, input logic hl, input logic sl,
                        input logic br, input logic jp, input logic zr,
                        input logic [7:0] imm, input logic [7:0] last);
    reset_n     = rst;
    start       = st;
    halt        = hl;
    stall       = sl;
    branch      = br;
    jump        = jp;
    zero        = zr;
    instruction = {$urandom_range(0, 32'h00FF_FFFF), 8'h00} | {24'h0, imm};
    last_addr   = last;
  endtask

  // Check outputs mid-cycle, then advance the model and DUT across one edge.
  task automatic step();
    @(negedge clock);
    chk("pc",   {24'h0, program_counter}, m_pc);
    chk("done", {31'h0, done},            (m_mode == 2) ? 1 : 0);
    chk("core_enable", {31'h0, core_enable},
        (m_mode == 1 && !halt && !stall) ? 1 : 0);
`ifdef MIPS_PC_RETIRE_COUNT_EN
    chk("retired", {16'h0, retired_count}, m_ret);
`endif
    @(posedge clock);
    if (!reset_n) begin
      m_mode = 0; m_pc = 0; m_ret = 0;
    end else if (m_mode == 0) begin
      if (start && !halt) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt) m_mode = 2;
      else if (!stall) begin
        m_ret = (m_ret + 1) % 65536;
        if (m_pc == int'(last_addr)) m_mode = 2;
        else if (jump)               m_pc = int'(instruction[7:0]);
        else if (branch && zero)     m_pc = (m_pc + 1 + int'(instruction[7:0])) % 256;
        else                         m_pc = (m_pc + 1) % 256;
      end
    end else begin
      if (start && !halt) begin
        m_mode = 1; m_pc = 0; m_ret = 0;
      end
    end
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    step(); step();
    chk("reset_pc", {24'h0, program_counter}, 0);
    chk("reset_done", {31'h0, done}, 0);

    // sequential run 0..3 then halt
    set_in(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'd3);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'd3);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", {24'h0, program_counter}, i);
    end
    step();
    chk("seq_done", {31'h0, done}, 1);
    chk("seq_hold", {24'h0, program_counter}, 3);
    step();
    chk("seq_hold2", {24'h0, program_counter}, 3);

    // branch taken/not taken and jump priority at pc=5
    set_in(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'd200);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'd200);
    repeat (5) step();
    chk("at5", {24'h0, program_counter}, 5);
    set_in(1, 0, 0, 0, 1, 0, 1, 8'hFC, 8'd200);
    step();
    chk("br_taken", {24'h0, program_counter}, 2);
    set_in(1, 0, 0, 0, 0, 1, 0, 8'h05, 8'd200);
    step();
    set_in(1, 0, 0, 0, 1, 0, 0, 8'hFC, 8'd200);
    step();
    chk("br_not_taken", {24'h0, program_counter}, 6);
    set_in(1, 0, 0, 0, 0, 1, 0, 8'h05, 8'd200);
    step();
    set_in(1, 0, 0, 0, 1, 1, 1, 8'h20, 8'd200);
    step();
    chk("jump_prio", {24'h0, program_counter}, 32);

    // wrap 255 -> 0 with last_addr=0
    set_in(1, 0, 0, 0, 0, 1, 0, 8'hFF, 8'd200);
    step();
    chk("at255", {24'h0, program_counter}, 255);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'd0);
    step();
    chk("wrap", {24'h0, program_counter}, 0);
    step();
    chk("wrap_done", {31'h0, done}, 1);

    // stall at pc=4
    set_in(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'd200);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'd200);
    repeat (4) step();
    set_in(1, 0, 0, 1, 0, 0, 0, 8'h00, 8'd200);
    repeat (3) begin
      step();
      chk("stall_pc", {24'h0, program_counter}, 4);
      chk("stall_ce", {31'h0, core_enable}, 0);
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'd200);
    step();
    chk("stall_resume", {24'h0, program_counter}, 5);

    // reset mid-run at pc=7 beats start/halt
    set_in(1, 0, 0, 0, 0, 1, 0, 8'h07, 8'd200);
    step();
    chk("at7", {24'h0, program_counter}, 7);
    set_in(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'd200);
    step();
    chk("rst_pc", {24'h0, program_counter}, 0);
    chk("rst_done", {31'h0, done}, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'd200);
    step();

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 4) == 0),
             $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0),
             $urandom_range(0, 1),
             8'($urandom_range(0, 255)),
             8'($urandom_range(0, 40)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
